// File: rtl/instr_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_pkg
//   Types and defaults shared by the fetch stage, its bus interface and the
//   neighbouring PC / decode stages.
//   - fetch_state_t : fetch FSM encoding (IDLE, ARMED, RUN, HALT)
//   - DEF_*         : default widths and the program-ending opcode
// ----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int DEF_PC_WIDTH    = 12;
    localparam int DEF_INSTR_WIDTH = 9;
    localparam int DEF_CNT_WIDTH   = 16;

    localparam logic [DEF_INSTR_WIDTH-1:0] DEF_HALT_OPCODE = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_if
//   Bundles every non-clock/reset signal of the fetch stage.
//   Program handshake: the environment holds start high to request a
//   program; the run begins on the cycle start is seen low again. done is
//   a level that rises the cycle after the HALT instruction issues and falls
//   when the next start request is accepted. instr/instr_pc are meaningful
//   only while instr_valid is high; decode has no back-pressure, so every
//   valid cycle is consumed.
//   modport master : the fetch stage itself
//   modport slave  : PC stage / instruction memory / decode / program driver
//   Signals:
//     start, current_pc, flush, imem_rdata        -> into the fetch stage
//     imem_addr, instr, instr_pc, instr_valid,
//     done, issued_cnt, state (debug)             <- out of the fetch stage
// ----------------------------------------------------------------------------
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) ();

    logic                   start;
    logic [PC_WIDTH-1:0]    current_pc;
    logic                   flush;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic                   instr_valid;
    logic                   done;
    logic [CNT_WIDTH-1:0]   issued_cnt;
    fetch_state_t           state;

    modport master (
        input  start, current_pc, flush, imem_rdata,
        output imem_addr, instr, instr_pc, instr_valid, done, issued_cnt, state
    );

    modport slave (
        output start, current_pc, flush, imem_rdata,
        input  imem_addr, instr, instr_pc, instr_valid, done, issued_cnt, state
    );

endinterface

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage behind the program counter. Presents current_pc to the
//   synchronous instruction memory, remembers which address is outstanding,
//   and issues the returned word to decode one cycle later tagged with its
//   address. A taken branch (flush) kills the outstanding read, leaving a
//   single bubble. The run ends when HALT_OPCODE is issued.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-high
//     bus    : instr_fetch_if.master (see interface header for signal list)
// ----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                     PC_WIDTH    = DEF_PC_WIDTH,
    parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = DEF_HALT_OPCODE,
    parameter int                     CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    fetch_state_t         state_q, state_d;
    logic                 req_v_q, req_v_d;
    logic [PC_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic issue;
    logic halt_issue;

    // A word is issued whenever a read launched last cycle survives; the
    // read data itself is passed straight through from the memory.
    assign issue      = (state_q == RUN) && req_v_q;
    assign halt_issue = issue && (bus.imem_rdata == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_v_q  <= req_v_d;
            req_pc_q <= req_pc_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_v_d  = req_v_q;
        req_pc_d = req_pc_q;
        done_d   = done_q;
        cnt_d    = cnt_q;

        if (issue && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                req_v_d = 1'b0;
                if (bus.start) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                req_v_d = 1'b0;
                // The release cycle already carries the first program
                // address, so the first read launches here; flush is not
                // meaningful before the run and is ignored.
                if (!bus.start) begin
                    state_d  = RUN;
                    req_v_d  = 1'b1;
                    req_pc_d = bus.current_pc;
                end
            end
            RUN: begin
                if (halt_issue) begin
                    // HALT is already out, so it outranks a same-cycle
                    // flush or start request.
                    state_d = HALT;
                    req_v_d = 1'b0;
                    done_d  = 1'b1;
                end else if (bus.start) begin
                    state_d = ARMED;
                    req_v_d = 1'b0;
                end else begin
                    req_v_d  = !bus.flush;
                    req_pc_d = bus.current_pc;
                end
            end
            HALT: begin
                req_v_d = 1'b0;
                if (bus.start) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = IDLE;
                req_v_d = 1'b0;
            end
        endcase

        // Every entry into ARMED starts a fresh program.
        if ((state_d == ARMED) && (state_q != ARMED)) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end
    end

    assign bus.imem_addr   = bus.current_pc;
    assign bus.instr_valid = issue;
    assign bus.instr       = issue ? bus.imem_rdata : '0;
    assign bus.instr_pc    = issue ? req_pc_q : '0;
    assign bus.done        = done_q;
    assign bus.issued_cnt  = cnt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A second instance with a 4-bit counter
//   shares all stimulus with the main one.
// ----------------------------------------------------------------------------
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk;
    logic reset;

    instr_fetch_if #(.PC_WIDTH(12), .INSTR_WIDTH(9), .CNT_WIDTH(16)) ifc ();
    instr_fetch_if #(.PC_WIDTH(12), .INSTR_WIDTH(9), .CNT_WIDTH(4))  ifc_s ();

    instr_fetch #(.PC_WIDTH(12), .INSTR_WIDTH(9), .HALT_OPCODE(9'h1FF), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    instr_fetch #(.PC_WIDTH(12), .INSTR_WIDTH(9), .HALT_OPCODE(9'h1FF), .CNT_WIDTH(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_s.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    logic [8:0] imem [0:4095];

    always @(posedge clk) begin
        ifc.imem_rdata <= imem[ifc.imem_addr];
    end

    assign ifc_s.start      = ifc.start;
    assign ifc_s.current_pc = ifc.current_pc;
    assign ifc_s.flush      = ifc.flush;
    assign ifc_s.imem_rdata = ifc.imem_rdata;

    // ---------------- scoreboard ----------------
    logic [20:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifc.instr_valid === 1'b1) begin
            logic [20:0] exp;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL issue_unexpected observed=%0h expected=none", {ifc.instr_pc, ifc.instr});
            end else begin
                exp = exp_q.pop_front();
                assert ({ifc.instr_pc, ifc.instr} === exp) else begin
                    errors++;
                    $error("FAIL issue_data observed=%0h expected=%0h", {ifc.instr_pc, ifc.instr}, exp);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Presents one address for one cycle; exp_issue says whether that
    // address must come out of fetch in the following cycle.
    task automatic step(input logic [11:0] pc, input logic fl, input logic st, input logic exp_issue);
        ifc.current_pc = pc;
        ifc.flush      = fl;
        ifc.start      = st;
        if (exp_issue) exp_q.push_back({pc, imem[pc]});
        @(posedge clk);
        #1;
        check("valid", 32'(ifc.instr_valid), 32'(exp_issue));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = 9'h000;
        imem[0] = 9'h001;
        imem[1] = 9'h002;
        imem[2] = 9'h003;
        imem[3] = 9'h1FF;
        imem[8] = 9'h008;
        imem[9] = 9'h1FF;
        for (int i = 10; i < 30; i++) imem[i] = 9'($urandom_range(0, 9'h1FE));
        imem[30] = 9'h1FF;

        reset          = 1'b1;
        ifc.start      = 1'b0;
        ifc.flush      = 1'b0;
        ifc.current_pc = 12'h000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(ifc.state), 32'(IDLE));
        check("rst_valid", 32'(ifc.instr_valid), 32'd0);
        check("rst_instr", 32'(ifc.instr), 32'd0);
        check("rst_instr_pc", 32'(ifc.instr_pc), 32'd0);
        check("rst_done", 32'(ifc.done), 32'd0);
        check("rst_cnt", 32'(ifc.issued_cnt), 32'd0);
        reset = 1'b0;

        // 1: basic program 1,2,3,HALT
        step(12'd0, 1'b0, 1'b1, 1'b0);
        check("t1_armed", 32'(ifc.state), 32'(ARMED));
        step(12'd0, 1'b0, 1'b1, 1'b0);
        step(12'd0, 1'b0, 1'b1, 1'b0);
        step(12'd0, 1'b0, 1'b0, 1'b1);
        check("t1_run", 32'(ifc.state), 32'(RUN));
        ifc.current_pc = 12'h5A5;
        #1;
        check("t1_imem_addr", 32'(ifc.imem_addr), 32'h5A5);
        step(12'd1, 1'b0, 1'b0, 1'b1);
        step(12'd2, 1'b0, 1'b0, 1'b1);
        check("t1_done_early", 32'(ifc.done), 32'd0);
        step(12'd3, 1'b0, 1'b0, 1'b1);
        step(12'd4, 1'b0, 1'b0, 1'b0);
        check("t1_state", 32'(ifc.state), 32'(HALT));
        check("t1_done", 32'(ifc.done), 32'd1);
        check("t1_cnt", 32'(ifc.issued_cnt), 32'd4);
        check("t1_cnt_s", 32'(ifc_s.issued_cnt), 32'd4);
        step(12'd5, 1'b0, 1'b0, 1'b0);

        // 3 + 2: restart from HALT, then branch at PC=2 to 8
        step(12'd0, 1'b0, 1'b1, 1'b0);
        check("t3_state", 32'(ifc.state), 32'(ARMED));
        check("t3_done", 32'(ifc.done), 32'd0);
        check("t3_cnt", 32'(ifc.issued_cnt), 32'd0);
        step(12'd0, 1'b0, 1'b1, 1'b0);
        step(12'd0, 1'b0, 1'b0, 1'b1);
        step(12'd1, 1'b0, 1'b0, 1'b1);
        step(12'd2, 1'b1, 1'b0, 1'b0);
        step(12'd8, 1'b0, 1'b0, 1'b1);
        step(12'd9, 1'b0, 1'b0, 1'b1);
        step(12'd10, 1'b0, 1'b0, 1'b0);
        check("t2_done", 32'(ifc.done), 32'd1);
        check("t2_cnt", 32'(ifc.issued_cnt), 32'd4);

        // 4: reset in the middle of a run
        step(12'd0, 1'b0, 1'b1, 1'b0);
        step(12'd0, 1'b0, 1'b1, 1'b0);
        step(12'd10, 1'b0, 1'b0, 1'b1);
        step(12'd11, 1'b0, 1'b0, 1'b1);
        step(12'd12, 1'b0, 1'b0, 1'b1);
        step(12'd13, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        step(12'd14, 1'b0, 1'b0, 1'b0);
        check("t4_state", 32'(ifc.state), 32'(IDLE));
        check("t4_done", 32'(ifc.done), 32'd0);
        check("t4_cnt", 32'(ifc.issued_cnt), 32'd0);
        reset = 1'b0;
        step(12'd15, 1'b0, 1'b0, 1'b0);
        step(12'd16, 1'b0, 1'b0, 1'b0);
        check("t4_idle", 32'(ifc.state), 32'(IDLE));

        // 5: abort by start during RUN; flush on release is ignored
        step(12'd0, 1'b0, 1'b1, 1'b0);
        step(12'd0, 1'b0, 1'b1, 1'b0);
        step(12'd10, 1'b1, 1'b0, 1'b1);
        step(12'd11, 1'b0, 1'b0, 1'b1);
        step(12'd12, 1'b0, 1'b0, 1'b1);
        step(12'd13, 1'b0, 1'b1, 1'b0);
        check("t5_state", 32'(ifc.state), 32'(ARMED));
        check("t5_done", 32'(ifc.done), 32'd0);
        check("t5_cnt", 32'(ifc.issued_cnt), 32'd0);
        step(12'd13, 1'b0, 1'b1, 1'b0);
        step(12'd0, 1'b0, 1'b0, 1'b1);
        step(12'd1, 1'b0, 1'b0, 1'b1);
        step(12'd2, 1'b0, 1'b0, 1'b1);
        step(12'd3, 1'b0, 1'b0, 1'b1);
        step(12'd4, 1'b0, 1'b0, 1'b0);
        check("t5_done_end", 32'(ifc.done), 32'd1);
        check("t5_cnt_end", 32'(ifc.issued_cnt), 32'd4);

        // 6: 20 instructions then HALT; flush coincides with HALT issue
        step(12'd0, 1'b0, 1'b1, 1'b0);
        step(12'd0, 1'b0, 1'b1, 1'b0);
        for (int pc = 10; pc <= 30; pc++) step(12'(pc), 1'b0, 1'b0, 1'b1);
        step(12'd31, 1'b1, 1'b0, 1'b0);
        check("t6_state", 32'(ifc.state), 32'(HALT));
        check("t6_done", 32'(ifc.done), 32'd1);
        check("t6_cnt", 32'(ifc.issued_cnt), 32'd21);
        check("t6_cnt_sat", 32'(ifc_s.issued_cnt), 32'd15);
        check("t6_done_s", 32'(ifc_s.done), 32'd1);
        step(12'd32, 1'b0, 1'b0, 1'b0);
        step(12'd33, 1'b0, 1'b0, 1'b0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
